// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Multi-read-port, single-write-port register file with
//               hardwired-zero x0, a post-reset scrub sequencer and a
//               per-register pending-load scoreboard.
//               Optional macro RF_BYPASS_EN enables write-through forwarding
//               of the writeback data onto matching read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic                     ready
);

    localparam int              c_depth = 1 << ADDR_W;
    localparam bit              c_zero  = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] c_last  = (ADDR_W+1)'(c_depth - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [c_depth-1:0]  r_pend;
    logic [c_depth-1:0]  w_pend_nxt;
    logic [DATA_W-1:0]   r_mem [c_depth];
    logic                w_wr_ok;
    logic                w_set_ok;

    // Writes/pend marks to x0 are discarded when x0 is hardwired
    assign w_wr_ok  = we && !(c_zero && (wa == '0));
    assign w_set_ok = pend_set && !(c_zero && (pend_addr == '0));

    // State register: reset always restarts the scrub
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state: leave INIT once the last entry has been cleared
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        case (r_state)
            INIT: if (r_cnt == c_last) w_state_nxt = RUN;
            RUN:  ready = 1'b1;
            default: w_state_nxt = INIT;
        endcase
    end

    // Scrub counter walks every entry once after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_cnt <= '0;
        else if (r_state == INIT)  r_cnt <= r_cnt + 1'b1;
    end

    // Pending next value: a new producer beats a same-cycle writeback
    always_comb begin
        w_pend_nxt = r_pend;
        if (we)       w_pend_nxt[wa]        = 1'b0;
        if (w_set_ok) w_pend_nxt[pend_addr] = 1'b1;
    end

    // Scoreboard only tracks loads once the file is in service
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_pend <= '0;
        else if (r_state == RUN)  r_pend <= w_pend_nxt;
    end

    // Storage: zeroed by the scrub, then written by writeback (no reset)
    always_ff @(posedge clk) begin
        if (r_state == INIT) r_mem[r_cnt[ADDR_W-1:0]] <= '0;
        else if (w_wr_ok)    r_mem[wa] <= wd;
    end

    // Asynchronous read ports, gated to zero until the scrub finishes
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_ra   = ra[k*ADDR_W +: ADDR_W];
        assign w_zero = c_zero && (w_ra == '0);
`ifdef RF_BYPASS_EN
        logic w_hit;
        // Forward the in-flight writeback; busy only if re-marked this cycle
        assign w_hit  = w_wr_ok && (wa == w_ra);
        assign w_data = w_hit ? wd : r_mem[w_ra];
        assign w_busy = w_hit ? (w_set_ok && (pend_addr == w_ra)) : r_pend[w_ra];
`else
        assign w_data = r_mem[w_ra];
        assign w_busy = r_pend[w_ra];
`endif
        assign rd[k*DATA_W +: DATA_W] = (ready && !w_zero) ? w_data : '0;
        assign rbusy[k]               = ready && !w_zero && w_busy;
    end

endmodule
`default_nettype wire
